// File: rtl/vga_box_renderer.sv
// Bouncing-box overlay for an 800x525 VGA raster: moves a square once per frame
// during vertical blanking and paints it over a flat background with 1-clk latency.
module vga_box_renderer #(
  parameter int          BOX_SIZE  = 32,
  parameter int          SPEED     = 2,
  parameter int          INIT_X    = 100,
  parameter int          INIT_Y    = 50,
  parameter logic [11:0] BOX_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR  = 12'h00F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y
);

  localparam logic [10:0] XMAX    = 11'(640 - BOX_SIZE);
  localparam logic [10:0] YMAX    = 11'(480 - BOX_SIZE);
  localparam logic [10:0] SPEED11 = 11'(SPEED);
  localparam logic [10:0] SIZE11  = 11'(BOX_SIZE);

  typedef enum logic {RUN, PAUSED} state_e;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
  } axis_t;

  state_e      state_q, state_d;
  logic [9:0]  boxX_q, boxY_q;
  logic        dx_q, dy_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, frameTick_q;
  logic        strobe, inBox;
  axis_t       xNext, yNext;

  // One axis of motion; all arithmetic is 11 bits wide so pos+SPEED cannot wrap.
  function automatic axis_t stepAxis(input logic [9:0] pos, input logic dir,
                                     input logic [10:0] lim);
    axis_t       r;
    logic [10:0] p, up, down;
    p    = {1'b0, pos};
    up   = p + SPEED11;
    down = p - SPEED11;
    r.pos = pos;
    r.dir = dir;
    if (dir) begin
      if (up >= lim) begin
        r.pos = lim[9:0];
        r.dir = 1'b0;
      end else begin
        r.pos = up[9:0];
      end
    end else begin
      if (p <= SPEED11) begin
        r.pos = 10'd0;
        r.dir = 1'b1;
      end else begin
        r.pos = down[9:0];
      end
    end
    return r;
  endfunction

  assign strobe = p_tick && (x == 10'd0) && (y == 10'd480);

  always_comb begin
    state_d = state_q;
    if (strobe) begin
      state_d = pause ? PAUSED : RUN;
    end
    xNext = stepAxis(boxX_q, dx_q, XMAX);
    yNext = stepAxis(boxY_q, dy_q, YMAX);
  end

  // Box hit test against the position registers of this very cycle.
  always_comb begin
    logic [10:0] px, py, bx, by;
    px    = {1'b0, x};
    py    = {1'b0, y};
    bx    = {1'b0, boxX_q};
    by    = {1'b0, boxY_q};
    inBox = (px >= bx) && (px < bx + SIZE11) && (py >= by) && (py < by + SIZE11);
    rgb_d = 12'h000;
    if (video_on) begin
      rgb_d = inBox ? BOX_COLOR : BG_COLOR;
    end
  end

  // The pause decision taken at the strobe already applies to that same update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      boxX_q      <= 10'(INIT_X);
      boxY_q      <= 10'(INIT_Y);
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      rgb_q       <= 12'h000;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      frameTick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frameTick_q <= strobe;
      if (strobe && state_d == RUN) begin
        boxX_q <= xNext.pos;
        dx_q   <= xNext.dir;
        boxY_q <= yNext.pos;
        dy_q   <= yNext.dir;
      end
      rgb_q   <= rgb_d;
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
    end
  end

  assign rgb        = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frameTick_q;
  assign box_x      = boxX_q;
  assign box_y      = boxY_q;

endmodule

// File: doc/vga_box_renderer.md
VGA_BOX_RENDERER -- requirements
Module: vga_box_renderer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BOX_SIZE, 32: square side in pixels.
- SPEED, 2: pixels moved per axis per frame.
- INIT_X, 100: reset X position of the box top-left corner.
- INIT_Y, 50: reset Y position of the box top-left corner.
- BOX_COLOR, 12'hF00: 4:4:4 RGB colour of the box.
- BG_COLOR, 12'h00F: 4:4:4 RGB colour of the background.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock, same as the sync generator's clock.
- reset, in, 1: synchronous, active-high reset.
- p_tick, in, 1: pixel tick from the sync generator, 1 clk in every 4.
- video_on, in, 1: visible-region flag.
- hsync_in, in, 1: horizontal sync from the sync generator.
- vsync_in, in, 1: vertical sync from the sync generator.
- x, in, 10: current pixel column, 0..799.
- y, in, 10: current pixel row, 0..524.
- pause, in, 1: when 1, freezes box motion.
- rgb, out, 12: pixel colour {R[3:0],G[3:0],B[3:0]}.
- hsync, out, 1: hsync_in delayed to align with rgb.
- vsync, out, 1: vsync_in delayed to align with rgb.
- frame_tick, out, 1: one-clk pulse on each position update.
- box_x, out, 10: current box X position.
- box_y, out, 10: current box Y position.

REQ-003 There SHALL be one clock domain (clk), and reset SHALL be synchronous and active-high.

Function
REQ-004 The update strobe SHALL be defined as p_tick && x==0 && y==480, which occurs exactly once per 800x525 frame, at the start of vertical blanking.

REQ-005 On the clk edge where the strobe is 1, frame_tick SHALL be 1 for exactly the following clk cycle; it SHALL be 0 at all other times.

REQ-006 The motion FSM SHALL have two states, RUN and PAUSED. The state SHALL be updated only at the strobe: pause=1 selects PAUSED and pause=0 selects RUN. The state sampled at the strobe SHALL govern that same update.

REQ-007 In PAUSED, box_x, box_y, dx and dy SHALL hold, and frame_tick SHALL still pulse.

REQ-008 In RUN, each axis SHALL update independently using the direction bit (dx or dy; 1 = increasing) and the axis limit (XMAX = 640-BOX_SIZE, YMAX = 480-BOX_SIZE):
- Increasing, pos+SPEED >= limit: pos becomes limit and the direction bit is cleared.
- Increasing, otherwise: pos becomes pos+SPEED.
- Decreasing, pos <= SPEED: pos becomes 0 and the direction bit is set.
- Decreasing, otherwise: pos becomes pos-SPEED.

REQ-009 The comparisons in REQ-008 SHALL be done at 11-bit width, so that no 10-bit wrap-around occurs. Position SHALL never leave 0..limit.

REQ-010 Each clk cycle, the block SHALL register the following, giving 1-clk latency from x, y, video_on to rgb:
- rgb = 12'h000 if video_on=0.
- Otherwise rgb = BOX_COLOR if box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE.
- Otherwise rgb = BG_COLOR.

REQ-011 hsync and vsync SHALL be hsync_in and vsync_in registered once, with no polarity change, so that they stay aligned with rgb.

REQ-012 The box test SHALL use the box_x and box_y register values current in the cycle. Because updates occur only during blanking, no frame SHALL show a torn box.

REQ-013 box_x and box_y SHALL be driven directly from the position registers.

Reset
REQ-014 While reset=1 at a clk edge, the block SHALL load:
- box_x = INIT_X, box_y = INIT_Y.
- dx = 1, dy = 1.
- state = RUN.
- rgb = 0, hsync = 0, vsync = 0, frame_tick = 0.

REQ-015 Reset SHALL override a coincident strobe; no position update occurs on that edge.

REQ-016 An assertion of reset mid-frame SHALL abandon any pending update. The first update after release SHALL occur at the next strobe.

Verification
REQ-017 The bench SHALL cover these scenarios (stimulus -> required response):
1. Reset for 2 clks, then release -> box_x=100, box_y=50, rgb=0, frame_tick=0.
2. One strobe with pause=0 -> box_x=102, box_y=52 one clk later; frame_tick high for exactly 1 clk.
3. box_x=606, dx=1, strobe -> box_x=608, dx=0. Next strobe -> box_x=606. Also, box_y=1, dy=0, strobe -> box_y=0, dy=1.
4. Box at (100,50), video_on=1:
   - x=100, y=50 -> rgb=12'hF00 one clk later.
   - x=131, y=81 -> rgb=12'hF00.
   - x=132, y=81 -> rgb=12'h00F.
   - video_on=0 -> rgb=12'h000.
   - hsync and vsync equal hsync_in and vsync_in delayed by exactly 1 clk.
5. pause=1 held over 3 strobes -> position unchanged and 3 frame_tick pulses. Then pause=0 -> motion resumes in the same direction.
6. Reset asserted at y=300 after 5 updates, reset coincident with a strobe -> box at (100,50); no update on the coincident edge.
